// File: rtl/usr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// usr_ctrl_pkg
// Shared definitions for the universal-shift-register command sequencer.
//   - USR select encodings (SEL_*)
//   - command op codes (OP_*)
//   - sequencer state enum
//   - op classification helpers
// Build option: USR_CTRL_ROTATE_EN enables the ROTL/ROTR ops. When it is
// undefined, rotate op codes classify as illegal (NOP behaviour).
// ----------------------------------------------------------------------------
package usr_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROTL = 3'b100;
    localparam logic [2:0] OP_ROTR = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    // True for ops that step the register through the SHIFT state.
    function automatic logic op_is_shift(input logic [2:0] op);
`ifdef USR_CTRL_ROTATE_EN
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) || (op == OP_ROTR);
`else
        return (op == OP_SHL) || (op == OP_SHR);
`endif
    endfunction

    // True for ops that move data towards the MSB (serial bit enters LSB).
    function automatic logic op_is_left(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_ROTL);
    endfunction

endpackage

// File: rtl/usr_shift_ctrl_step_counter.sv
// ----------------------------------------------------------------------------
// usr_step_counter
// Loadable CNT_W-bit down-counter tracking remaining shift steps.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears count)
//   i_load       : load i_load_val (takes priority over decrement)
//   i_load_val   : step count to load
//   i_dec        : decrement by one (saturates at zero)
//   i_clr        : clear count to zero (used on abort)
//   o_last       : count == 1, i.e. the current step is the final one
// ----------------------------------------------------------------------------
module usr_step_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/usr_shift_ctrl.sv
// ----------------------------------------------------------------------------
// usr_shift_ctrl
// Command sequencer for a universal shift register (USR). Accepts one
// command over a valid/ready handshake, drives the USR select / parallel /
// serial inputs for the required number of cycles and pulses done.
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready; cmd_ready is high only in IDLE and not in reset.
// The requester must hold cmd_valid and its fields stable until transfer.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/count/data/fill : command fields (latched on accept)
//   cmd_abort           : cancel a LOAD/SHIFT in progress (no done pulse)
//   usr_q               : USR contents, feedback for rotates
//   usr_select/usr_inp/usr_serialin : USR control outputs
//   busy, done          : in-progress flag, one-cycle completion pulse
//   dbg_state           : current sequencer state
// Build option: USR_CTRL_ROTATE_EN enables ROTL/ROTR and the rotate feedback.
// ----------------------------------------------------------------------------
module usr_shift_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             cmd_abort,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_inp,
    output logic             usr_serialin,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_fill;

    logic w_accept;
    logic w_last;
    logic w_abort;

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;
    // Abort only has meaning while the USR is being driven.
    assign w_abort   = cmd_abort && ((r_state == LOAD) || (r_state == SHIFT));

    usr_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (cmd_count),
        .i_dec      (r_state == SHIFT),
        .i_clr      (w_abort),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= OP_NOP;
            r_data  <= '0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        r_fill <= cmd_fill;
                        if (cmd_op == OP_LOAD) begin
                            r_state <= LOAD;
                        end else if (op_is_shift(cmd_op) && (cmd_count != '0)) begin
                            r_state <= SHIFT;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    r_state <= w_abort ? IDLE : DONE;
                end
                SHIFT: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of the USR controls from registered state.
    always_comb begin
        usr_select = SEL_HOLD;
        case (r_state)
            LOAD:    usr_select = SEL_LOAD;
            SHIFT:   usr_select = op_is_left(r_op) ? SEL_SHL : SEL_SHR;
            default: usr_select = SEL_HOLD;
        endcase
    end

    // Rotates feed back the bit falling off the far end, taken directly
    // from usr_q so that each SHIFT cycle rotates by exactly one place.
    always_comb begin
        usr_serialin = 1'b0;
        if (r_state == SHIFT) begin
`ifdef USR_CTRL_ROTATE_EN
            if (r_op == OP_ROTL) begin
                usr_serialin = usr_q[WIDTH-1];
            end else if (r_op == OP_ROTR) begin
                usr_serialin = usr_q[0];
            end else begin
                usr_serialin = r_fill;
            end
`else
            usr_serialin = r_fill;
`endif
        end
    end

`ifndef USR_CTRL_ROTATE_EN
    // Feedback is not needed without rotates.
    logic w_unused_q;
    assign w_unused_q = ^usr_q;
`endif

    assign usr_inp   = r_data;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// ----------------------------------------------------------------------------
// tb_usr_shift_ctrl
// Bench for usr_shift_ctrl with a behavioural 4-bit USR closing the loop.
// Drivers push expected (usr_q, latency, active-select cycles, select) per
// command; a negedge monitor pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_usr_shift_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_fill = 1'b0;
  logic             cmd_abort = 1'b0;
  logic [WIDTH-1:0] usr_q = '0;
  logic [1:0]       usr_select;
  logic [WIDTH-1:0] usr_inp;
  logic             usr_serialin;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  usr_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_count    (cmd_count),
    .cmd_data     (cmd_data),
    .cmd_fill     (cmd_fill),
    .cmd_abort    (cmd_abort),
    .usr_q        (usr_q),
    .usr_select   (usr_select),
    .usr_inp      (usr_inp),
    .usr_serialin (usr_serialin),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural USR ----------------
  always @(posedge clk) begin
    case (usr_select)
      2'b01:   usr_q <= {usr_q[WIDTH-2:0], usr_serialin};
      2'b10:   usr_q <= {usr_serialin, usr_q[WIDTH-1:1]};
      2'b11:   usr_q <= usr_inp;
      default: usr_q <= usr_q;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               exp_lat_q[$];
  int               exp_act_q[$];
  logic [1:0]       exp_sel_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int         cyc = 0;
  int         acc_cyc = 0;
  int         last_acc_cyc = 0;
  int         last_done_cyc = 0;
  int         act_cnt = 0;
  logic [1:0] sel_or = 2'b00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset && (usr_select != 2'b00)) begin
      act_cnt++;
      sel_or = sel_or | usr_select;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
      end else begin
        check("done_usr_q",   32'(usr_q),               32'(exp_q.pop_front()));
        check("done_latency", 32'(cyc - acc_cyc),       32'(exp_lat_q.pop_front()));
        check("active_cycles", 32'(act_cnt),            32'(exp_act_q.pop_front()));
        check("select_used",  32'(sel_or),              32'(exp_sel_q.pop_front()));
      end
      last_done_cyc = cyc;
    end
    if (cmd_valid && cmd_ready) begin
      acc_cyc      = cyc;
      last_acc_cyc = cyc;
      act_cnt      = 0;
      sel_or       = 2'b00;
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                       input logic [WIDTH-1:0] data, input logic fill, input bit push,
                       input logic [WIDTH-1:0] eq, input int el, input int ea,
                       input logic [1:0] es);
    bit got;
    got = 1'b0;
    if (push) begin
      exp_q.push_back(eq);
      exp_lat_q.push_back(el);
      exp_act_q.push_back(ea);
      exp_sel_q.push_back(es);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 60 cycles expected 1 (op %0d)", op);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 for 60 cycles expected 0");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready),    32'd0);
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_done",      32'(done),         32'd0);
    check("rst_select",    32'(usr_select),   32'd0);
    check("rst_inp",       32'(usr_inp),      32'd0);
    check("rst_serialin",  32'(usr_serialin), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // LOAD 1011: done 2 cycles after accept, select 11 for one cycle
    issue(3'b001, 3'd0, 4'b1011, 1'b0, 1'b1, 4'b1011, 2, 1, 2'b11);
    wait_idle();

    // LOAD 1111, SHL 2 fill 0 -> 1100
    issue(3'b001, 3'd0, 4'b1111, 1'b0, 1'b1, 4'b1111, 2, 1, 2'b11);
    wait_idle();
    issue(3'b010, 3'd2, 4'b0000, 1'b0, 1'b1, 4'b1100, 3, 2, 2'b01);
    wait_idle();

    // LOAD 0000, SHR 3 fill 1 -> 1110, with a held SHL count 0 behind it
    issue(3'b001, 3'd0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2, 1, 2'b11);
    wait_idle();
    issue(3'b011, 3'd3, 4'b0000, 1'b1, 1'b1, 4'b1110, 4, 3, 2'b10);
    issue(3'b010, 3'd0, 4'b0000, 1'b0, 1'b1, 4'b1110, 1, 0, 2'b00);
    check("held_accept_after_done", 32'(last_acc_cyc - last_done_cyc), 32'd1);
    wait_idle();

    // Rotates
    issue(3'b001, 3'd0, 4'b1011, 1'b0, 1'b1, 4'b1011, 2, 1, 2'b11);
    wait_idle();
`ifdef USR_CTRL_ROTATE_EN
    issue(3'b100, 3'd1, 4'b0000, 1'b0, 1'b1, 4'b0111, 2, 1, 2'b01);
    wait_idle();
    issue(3'b101, 3'd4, 4'b0000, 1'b0, 1'b1, 4'b0111, 5, 4, 2'b10);
    wait_idle();
`else
    issue(3'b100, 3'd1, 4'b0000, 1'b0, 1'b1, 4'b1011, 1, 0, 2'b00);
    wait_idle();
    issue(3'b101, 3'd4, 4'b0000, 1'b0, 1'b1, 4'b1011, 1, 0, 2'b00);
    wait_idle();
`endif

    // Illegal op 110 behaves as NOP
    issue(3'b110, 3'd5, 4'b0000, 1'b1, 1'b1, usr_q, 1, 0, 2'b00);
    wait_idle();

    // Reset in the middle of SHR count 5
    issue(3'b001, 3'd0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2, 1, 2'b11);
    wait_idle();
    issue(3'b011, 3'd5, 4'b0000, 1'b1, 1'b0, 4'b0000, 0, 0, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("after_rst_select",   32'(usr_select),   32'd0);
    check("after_rst_busy",     32'(busy),         32'd0);
    check("after_rst_done",     32'(done),         32'd0);
    check("after_rst_serialin", 32'(usr_serialin), 32'd0);
    check("after_rst_inp",      32'(usr_inp),      32'd0);
    check("after_rst_ready",    32'(cmd_ready),    32'd1);

    // Abort in the middle of SHL count 6 fill 1: three steps land
    issue(3'b001, 3'd0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2, 1, 2'b11);
    wait_idle();
    issue(3'b010, 3'd6, 4'b0000, 1'b1, 1'b0, 4'b0000, 0, 0, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1 cmd_abort = 1'b1;
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    @(negedge clk);
    check("abort_ready",   32'(cmd_ready), 32'd1);
    check("abort_busy",    32'(busy),      32'd0);
    check("abort_partial", 32'(usr_q),     32'(4'b0111));
    repeat (3) @(negedge clk);
    check("abort_no_busy", 32'(busy), 32'd0);

    // Command works normally after an abort
    issue(3'b011, 3'd1, 4'b0000, 1'b0, 1'b1, 4'b0011, 2, 1, 2'b10);
    wait_idle();

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
